polyw1_unpack_stream: RTL and testbench



---
 rtl/polyw1_pkg.sv | 8 +
 rtl/polyw1_unpack_stream.sv | 73 +++++++
 tb/tb_polyw1_unpack_stream.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/polyw1_pkg.sv
// polyw1_pkg: shared sizes and unpacker FSM states for the packed w1 datapath
package polyw1_pkg;
    localparam int N = 256;
    localparam int POLYW1_BYTES = 128;
    localparam int COEF_W = 32;
    localparam int W1_BITS = 4;
    typedef enum logic [1:0] {EMPTY, LO, HI} state_t;
endpackage

// File: rtl/polyw1_unpack_stream.sv
// polyw1_unpack_stream: streams packed w1 bytes out as 4-bit coefficients, low nibble first
// POLYW1_UNPACK_INDEX_EN adds the coef_idx output
module polyw1_unpack_stream
    import polyw1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_last,
    output logic              poly_done,
    output logic              err
`ifdef POLYW1_UNPACK_INDEX_EN
    ,
    output logic [7:0]        coef_idx
`endif
);
    state_t state, state_n;
    logic [7:0] byte_q, coef_cnt;
    logic [6:0] byte_cnt;
    logic in_hs, out_hs;
    assign in_ready = !clr && (state == EMPTY || (state == HI && coef_ready));
    assign in_hs = in_valid && in_ready;
    assign out_hs = coef_valid && coef_ready;
    assign coef_valid = state != EMPTY;
    assign coef_data = {{(COEF_W-W1_BITS){1'b0}},
                        state == LO ? byte_q[3:0] : state == HI ? byte_q[7:4] : 4'h0};
    assign coef_last = coef_valid && coef_cnt == 8'(N-1);
`ifdef POLYW1_UNPACK_INDEX_EN
    assign coef_idx = coef_cnt;
`endif
    // A new byte can only be taken while the high nibble leaves, so this holds at most one byte.
    always_comb begin
        state_n = state;
        state_n = in_hs ? LO :
                  (state == LO && coef_ready) ? HI :
                  (state == HI && coef_ready) ? EMPTY : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            byte_q    <= '0;
            byte_cnt  <= '0;
            coef_cnt  <= '0;
            err       <= 1'b0;
            poly_done <= 1'b0;
        end else if (clr) begin
            state     <= EMPTY;
            byte_q    <= '0;
            byte_cnt  <= '0;
            coef_cnt  <= '0;
            err       <= 1'b0;
            poly_done <= 1'b0;
        end else begin
            state <= state_n;
            if (in_hs) begin
                byte_q   <= in_data;
                byte_cnt <= byte_cnt + 7'd1;
            end
            if (in_hs && (in_last != (byte_cnt == 7'(POLYW1_BYTES-1))))
                err <= 1'b1;
            if (out_hs)
                coef_cnt <= coef_cnt + 8'd1;
            poly_done <= out_hs && coef_last;
        end
    end
endmodule

// File: tb/tb_polyw1_unpack_stream.sv
// tb_polyw1_unpack_stream: randomized self-checking bench against a nibble-queue reference model
module tb_polyw1_unpack_stream;
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic in_valid = 1'b0, in_ready, in_last = 1'b0, coef_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic coef_valid, coef_last, poly_done, err;
    logic [31:0] coef_data;
`ifdef POLYW1_UNPACK_INDEX_EN
    logic [7:0] coef_idx;
`endif
    int tests = 0, fails = 0;
    int q[$];
    int out_idx = 0, in_idx = 0;
    bit m_err = 0, pd = 0, ihs, ohs;
    logic [7:0] bb [0:127];

    always #5 clk = ~clk;

    polyw1_unpack_stream dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .coef_last(coef_last), .poly_done(poly_done), .err(err)
`ifdef POLYW1_UNPACK_INDEX_EN
        , .coef_idx(coef_idx)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        out_idx = 0;
        in_idx = 0;
        m_err = 0;
        pd = 0;
    endtask

    // Outstanding nibbles = accepted minus emitted; the block holds at most one byte.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r, input bit c);
        bit ev, er;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; coef_ready = r; clr = c;
        #1;
        ev = q.size() != 0;
        er = !c && (q.size() == 0 || (q.size() == 1 && r));
        chk("coef_valid", 32'(coef_valid), 32'(ev));
        chk("coef_data", coef_data, ev ? q[0] : 0);
        chk("coef_last", 32'(coef_last), 32'(ev && out_idx == 255));
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("poly_done", 32'(poly_done), 32'(pd));
        chk("err", 32'(err), 32'(m_err));
`ifdef POLYW1_UNPACK_INDEX_EN
        chk("coef_idx", 32'(coef_idx), out_idx);
`endif
        ihs = v && er;
        ohs = ev && r;
        if (c) model_clear();
        else begin
            pd = ohs && out_idx == 255;
            if (ohs) begin
                void'(q.pop_front());
                out_idx = (out_idx + 1) % 256;
            end
            if (ihs) begin
                if (l != (in_idx == 127)) m_err = 1;
                in_idx = (in_idx + 1) % 128;
                q.push_back(int'(d[3:0]));
                q.push_back(int'(d[7:4]));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; coef_ready = 1'b0; in_last = 1'b0;
        #1;
        chk("rst_coef_valid", 32'(coef_valid), 0);
        chk("rst_coef_data", coef_data, 0);
        chk("rst_coef_last", 32'(coef_last), 0);
        chk("rst_poly_done", 32'(poly_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_stream(input int start, input int nbytes, input int last_at,
                              input int rdy_pct, input int vld_pct, input bit gap_check);
        int pos, cyc, first, lastout;
        bit v, r;
        pos = start; cyc = 0; first = -1; lastout = -1;
        while ((pos < nbytes || q.size() != 0) && cyc < 4000) begin
            v = pos < nbytes && ($urandom_range(99) < vld_pct);
            r = $urandom_range(99) < rdy_pct;
            step(v, v ? bb[pos] : 8'($urandom), v && pos == last_at, r, 1'b0);
            if (ihs) begin
                if (first < 0) first = cyc;
                pos++;
            end
            if (ohs) lastout = cyc;
            cyc++;
        end
        chk("stream_in_budget", 32'(cyc < 4000), 1);
        if (gap_check) chk("gapless_256", lastout - first, 256);
    endtask

    initial begin
        do_reset();
        // two bytes -> coefficients 1,2,3,4 back to back
        bb[0] = 8'h21; bb[1] = 8'h43;
        run_stream(0, 2, -1, 100, 100, 0);
        do_reset();
        // full polynomial, byte i = 2i, always ready
        for (int i = 0; i < 128; i++) bb[i] = 8'(i * 2);
        run_stream(0, 128, 127, 100, 100, 1);
        chk("full_err", 32'(err), 0);
        // random data, random handshakes, with a 5-cycle stall in HI first
        for (int i = 0; i < 128; i++) bb[i] = 8'($urandom);
        step(1'b1, bb[0], 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, bb[1], 1'b0, 1'b0, 1'b0);
        run_stream(1, 128, 127, 50, 70, 0);
        run_stream(0, 128, 127, 60, 60, 0);
        // misplaced in_last sets sticky err; clr clears it and restarts counting
        for (int i = 0; i < 128; i++) bb[i] = 8'($urandom);
        run_stream(0, 128, 50, 80, 80, 0);
        chk("err_sticky", 32'(err), 1);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        run_stream(0, 128, 127, 90, 90, 0);
        chk("err_after_clr", 32'(err), 0);
        // clr in LO drops the held byte and refuses the offered one
        step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        // reset mid-polynomial, then a clean polynomial
        run_stream(0, 40, 127, 70, 70, 0);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 128; i++) bb[i] = 8'($urandom);
        run_stream(0, 128, 127, 75, 85, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
